// File: rtl/eh2_lsu_clken_gen_if.sv
// eh2_lsu_clken_gen_if: LSU activity inputs and clock-enable outputs bundled between LSU top and clken generator
interface eh2_lsu_clken_gen_if #(
  parameter int NUM_STAGES  = 5,
  parameter int NUM_THREADS = 2
);
  logic                   clk_override;
  logic [NUM_STAGES-1:0]  pkt_valid;
  logic [NUM_STAGES-1:0]  pkt_store;
  logic                   dma_req;
  logic                   dma_write;
  logic [NUM_THREADS-1:0] lr_vld;
  logic [NUM_THREADS-1:0] busreq;
  logic [NUM_THREADS-1:0] bus_pend;
  logic [NUM_THREADS-1:0] bus_empty;
  logic [NUM_THREADS-1:0] bus_idle;
  logic [NUM_THREADS-1:0] stbuf_empty;
  logic [NUM_THREADS-1:0] force_halt;
  logic [NUM_THREADS-1:0] force_halt_bus;
  logic                   bus_clk_en;
  logic [NUM_STAGES-1:0]  c1_clken;
  logic [NUM_STAGES-1:0]  c2_clken;
  logic [NUM_STAGES-1:0]  store_c1_clken;
  logic [NUM_THREADS-1:0] buf_clken;
  logic [NUM_THREADS-1:0] obuf_clken;
  logic                   busm_clken;
  logic                   free_c2_clken;
  logic                   lsu_idle;
  modport master (
    output clk_override, pkt_valid, pkt_store, dma_req, dma_write, lr_vld, busreq, bus_pend,
           bus_empty, bus_idle, stbuf_empty, force_halt, force_halt_bus, bus_clk_en,
    input  c1_clken, c2_clken, store_c1_clken, buf_clken, obuf_clken, busm_clken, free_c2_clken, lsu_idle
  );
  modport slave (
    input  clk_override, pkt_valid, pkt_store, dma_req, dma_write, lr_vld, busreq, bus_pend,
           bus_empty, bus_idle, stbuf_empty, force_halt, force_halt_bus, bus_clk_en,
    output c1_clken, c2_clken, store_c1_clken, buf_clken, obuf_clken, busm_clken, free_c2_clken, lsu_idle
  );
endinterface

// File: rtl/eh2_lsu_clken_gen.sv
// eh2_lsu_clken_gen: LSU per-stage, per-thread bus-buffer and free-clock enables with hold-off counters and idle flag
module eh2_lsu_clken_gen #(
  parameter int NUM_STAGES  = 5,
  parameter int NUM_THREADS = 2,
  parameter int HOLD_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  eh2_lsu_clken_gen_if.slave io
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);
  logic [NUM_STAGES-1:0] c1_q, c1_d;
  logic [NUM_THREADS-1:0][CNT_W-1:0] buf_cnt_q, buf_cnt_d;
  logic [CNT_W-1:0] free_cnt_q, free_cnt_d;
  logic idle_q, idle_d;
  logic [NUM_THREADS-1:0] buf_act;
  logic free_act;
  always_comb begin
    c1_d = io.pkt_valid | {c1_q[NUM_STAGES-2:0], 1'b0} | (NUM_STAGES'(io.dma_req) << 1) | {NUM_STAGES{io.clk_override}};
    io.c1_clken = c1_d;
    io.c2_clken = c1_d | c1_q;
    io.store_c1_clken = (c1_d & (io.pkt_store | (NUM_STAGES'(io.dma_write) << 1))) | {NUM_STAGES{io.clk_override}};
    buf_act = ~io.bus_empty | io.busreq | io.force_halt;
    buf_cnt_d = buf_cnt_q;
    io.buf_clken = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      buf_cnt_d[t] = buf_act[t] ? HOLD : (buf_cnt_q[t] != '0) ? buf_cnt_q[t] - CNT_W'(1) : '0;
      io.buf_clken[t] = buf_act[t] | (buf_cnt_q[t] != '0) | io.clk_override;
    end
    free_act = (|io.pkt_valid) | (|io.lr_vld) | ~(&io.bus_empty) | ~(&io.stbuf_empty);
    free_cnt_d = free_act ? HOLD : (free_cnt_q != '0) ? free_cnt_q - CNT_W'(1) : '0;
    io.free_c2_clken = free_act | (free_cnt_q != '0) | io.clk_override;
    idle_d = ~io.free_c2_clken;
    io.lsu_idle = idle_q;
    io.obuf_clken = (io.bus_pend | io.busreq | {NUM_THREADS{io.clk_override}}) & {NUM_THREADS{io.bus_clk_en}};
    io.busm_clken = (~(&io.bus_empty) | ~(&io.bus_idle) | (|io.force_halt_bus) | (|io.busreq) | io.clk_override)
                    & io.bus_clk_en;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      c1_q <= '0;
      buf_cnt_q <= '0;
      free_cnt_q <= '0;
      idle_q <= 1'b0;
    end else begin
      c1_q <= c1_d;
      buf_cnt_q <= buf_cnt_d;
      free_cnt_q <= free_cnt_d;
      idle_q <= idle_d;
    end
  end
  // Bus requests come from a single last-stage packet, so at most one thread may request.
  always_ff @(posedge clk) begin
    if (!rst) assert ($onehot0(io.busreq)) else $error("busreq has more than one bit set: %b", io.busreq);
  end
endmodule

// File: tb/tb_eh2_lsu_clken_gen.sv
// tb_eh2_lsu_clken_gen: directed scenarios plus random traffic against a cycle-history reference model
module tb_eh2_lsu_clken_gen;
  localparam int NS = 5;
  localparam int NT = 2;
  localparam int HOLD = 4;
  localparam int NEVER = -100000;
  logic clk = 1'b0;
  logic rst;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [NS-1:0] m_c1;
  int buf_last [NT];
  int free_last;
  logic m_idle;
  eh2_lsu_clken_gen_if #(.NUM_STAGES(NS), .NUM_THREADS(NT)) io ();
  eh2_lsu_clken_gen #(.NUM_STAGES(NS), .NUM_THREADS(NT), .HOLD_CYCLES(HOLD)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic held(input int last);
    return (cyc - last >= 1) && (cyc - last <= HOLD);
  endfunction

  task automatic idle_inputs();
    io.clk_override = 0; io.pkt_valid = '0; io.pkt_store = '0; io.dma_req = 0; io.dma_write = 0;
    io.lr_vld = '0; io.busreq = '0; io.bus_pend = '0; io.bus_empty = '1; io.bus_idle = '1;
    io.stbuf_empty = '1; io.force_halt = '0; io.force_halt_bus = '0; io.bus_clk_en = 1;
  endtask

  task automatic step();
    logic [NS-1:0] e_c1, e_c2, e_st;
    logic [NT-1:0] act, e_buf, e_obuf;
    logic fa, e_free, e_busm, ovr;
    #1;
    ovr = io.clk_override;
    for (int k = 0; k < NS; k++) begin
      e_c1[k] = io.pkt_valid[k] | ovr | ((k > 0) ? m_c1[k-1] : 1'b0) | ((k == 1) ? io.dma_req : 1'b0);
      e_c2[k] = e_c1[k] | m_c1[k];
      e_st[k] = (e_c1[k] & (io.pkt_store[k] | ((k == 1) ? io.dma_write : 1'b0))) | ovr;
    end
    for (int t = 0; t < NT; t++) begin
      act[t] = !io.bus_empty[t] || io.busreq[t] || io.force_halt[t];
      e_buf[t] = act[t] | held(buf_last[t]) | ovr;
      e_obuf[t] = (io.bus_pend[t] | io.busreq[t] | ovr) & io.bus_clk_en;
    end
    fa = (io.pkt_valid != 0) || (io.lr_vld != 0) || (io.bus_empty != {NT{1'b1}}) || (io.stbuf_empty != {NT{1'b1}});
    e_free = fa | held(free_last) | ovr;
    e_busm = ((io.bus_empty != {NT{1'b1}}) || (io.bus_idle != {NT{1'b1}}) || (io.force_halt_bus != 0)
              || (io.busreq != 0) || ovr) & io.bus_clk_en;
    chk("c1_clken", 32'(io.c1_clken), 32'(e_c1));
    chk("c2_clken", 32'(io.c2_clken), 32'(e_c2));
    chk("store_c1_clken", 32'(io.store_c1_clken), 32'(e_st));
    chk("buf_clken", 32'(io.buf_clken), 32'(e_buf));
    chk("obuf_clken", 32'(io.obuf_clken), 32'(e_obuf));
    chk("busm_clken", 32'(io.busm_clken), 32'(e_busm));
    chk("free_c2_clken", 32'(io.free_c2_clken), 32'(e_free));
    chk("lsu_idle", 32'(io.lsu_idle), 32'(m_idle));
    @(posedge clk);
    if (rst) begin
      m_c1 = '0; free_last = NEVER; m_idle = 0;
      for (int t = 0; t < NT; t++) buf_last[t] = NEVER;
    end else begin
      m_c1 = e_c1; m_idle = !e_free;
      if (fa) free_last = cyc;
      for (int t = 0; t < NT; t++) if (act[t]) buf_last[t] = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int r;
    m_c1 = '0; free_last = NEVER; m_idle = 0;
    for (int t = 0; t < NT; t++) buf_last[t] = NEVER;
    rst = 1;
    idle_inputs();
    @(negedge clk);
    step();
    #1 chk("reset_idle", 32'(io.lsu_idle), 32'd0);
    chk("reset_c2", 32'(io.c2_clken), 32'd0);
    step();
    rst = 0;
    step();
    // pipeline pulse travels one stage per cycle
    io.pkt_valid = 5'b00001;
    #1 chk("t1_c1_first", 32'(io.c1_clken), 32'h01);
    step();
    io.pkt_valid = '0;
    for (int i = 0; i < 7; i++) step();
    // single thread-1 buffer activity, held HOLD cycles
    io.bus_empty = 2'b01;
    step();
    io.bus_empty = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1 chk("t2_buf_hold", 32'(io.buf_clken), (i < HOLD) ? 32'h2 : 32'h0);
      step();
    end
    io.busreq = 2'b01; io.bus_clk_en = 0;
    #1 chk("t3_obuf_gated", 32'(io.obuf_clken), 32'h0);
    step();
    io.bus_clk_en = 1;
    #1 chk("t3_busm_on", 32'(io.busm_clken), 32'h1);
    step();
    io.busreq = '0;
    for (int i = 0; i < 6; i++) step();
    io.clk_override = 1;
    #1 chk("t4_ovr_c2", 32'(io.c2_clken), 32'h1f);
    chk("t4_ovr_buf", 32'(io.buf_clken), 32'h3);
    step();
    io.clk_override = 0;
    #1 chk("t4_idle_after_ovr", 32'(io.lsu_idle), 32'h0);
    step();
    for (int i = 0; i < 6; i++) step();
    // reset while the free hold counter is mid-count
    io.pkt_valid = 5'b00010;
    step();
    io.pkt_valid = '0;
    step();
    rst = 1;
    step();
    rst = 0;
    #1 chk("t5_free_cleared", 32'(io.free_c2_clken), 32'h0);
    chk("t5_idle_low", 32'(io.lsu_idle), 32'h0);
    step();
    #1 chk("t5_idle_high", 32'(io.lsu_idle), 32'h1);
    step();
    // re-trigger on the last hold cycle keeps free clock continuous
    io.lr_vld = 2'b10;
    step();
    io.lr_vld = '0;
    for (int i = 0; i < 3; i++) step();
    io.lr_vld = 2'b01;
    step();
    io.lr_vld = '0;
    for (int i = 0; i < HOLD + 2; i++) begin
      #1 chk("t6_free_cont", 32'(io.free_c2_clken), (i < HOLD) ? 32'h1 : 32'h0);
      step();
    end
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      io.clk_override = ($urandom_range(0, 19) == 0);
      io.pkt_valid = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      io.pkt_store = NS'($urandom);
      io.dma_req = ($urandom_range(0, 5) == 0);
      io.dma_write = 1'($urandom);
      io.lr_vld = ($urandom_range(0, 7) == 0) ? NT'($urandom) : '0;
      r = $urandom_range(0, 3 * NT);
      io.busreq = (r < NT) ? NT'(1 << r) : '0;
      io.bus_pend = NT'($urandom);
      io.bus_empty = ($urandom_range(0, 5) == 0) ? NT'($urandom) : '1;
      io.bus_idle = ($urandom_range(0, 3) == 0) ? NT'($urandom) : '1;
      io.stbuf_empty = ($urandom_range(0, 7) == 0) ? NT'($urandom) : '1;
      io.force_halt = ($urandom_range(0, 9) == 0) ? NT'($urandom) : '0;
      io.force_halt_bus = ($urandom_range(0, 9) == 0) ? NT'($urandom) : '0;
      io.bus_clk_en = 1'($urandom);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
